// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the ROM address and
// fills the IF/ID register, with stall/flush/redirect, self-jump halt and fault flag.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int          ROM_WORDS         = 64,
  parameter bit          HALT_ON_SELF_JUMP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        err,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [31:0] LIMIT = 32'(ROM_WORDS * 4);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        fault;
  logic        self_jump;

  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;
  assign fault     = (pc[1:0] != 2'b00) || (pc >= LIMIT);

  // J whose pseudo-direct target lands on its own address
  assign self_jump = HALT_ON_SELF_JUMP
                   && (imem_rdata[31:26] == 6'b000010)
                   && ({pc[31:28], imem_rdata[25:0], 2'b00} == pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ifid_instr  <= 32'd0;
      ifid_pc4    <= 32'd0;
      ifid_valid  <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          ifid_valid <= 1'b0;
          if (start) begin
            pc    <= RESET_PC;
            state <= RUN;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            pc         <= redirect_pc;
            ifid_valid <= 1'b0;
          end else if (fault && !stall) begin
            ifid_valid <= 1'b0;
            err        <= 1'b1;
            halted     <= 1'b1;
            state      <= HALT;
          end else if (flush) begin
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            ifid_instr  <= imem_rdata;
            ifid_pc4    <= pc4;
            ifid_valid  <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            if (self_jump) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc <= pc4;
            end
          end
        end
        HALT: begin
          ifid_valid <= 1'b0;
          if (start) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            state  <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a ROM model and a capture
// scoreboard of expected IF/ID contents.
module tb_fetch_sequencer;

  localparam int ROM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic        err;
  logic [31:0] fetch_count;

  logic [31:0] rom [ROM_WORDS];
  logic [63:0] sb [$];
  int total = 0;
  int bad = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 32'(ROM_WORDS * 4))
                    ? rom[imem_addr[7:2]] : 32'd0;

  fetch_sequencer #(
    .RESET_PC(32'h0),
    .ROM_WORDS(ROM_WORDS),
    .HALT_ON_SELF_JUMP(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stall(stall),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid),
    .halted(halted),
    .err(err),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_instr"}, ifid_instr, 32'd0);
    chk({tag, "_pc4"}, ifid_pc4, 32'd0);
    chk({tag, "_valid"}, 32'(ifid_valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cnt"}, fetch_count, 32'd0);
  endtask

  // one normal fetch: predict the capture, clock it, compare it
  task automatic fetch(input string tag);
    logic [63:0] e;
    chk({tag, "_addr"}, imem_addr, exp_pc);
    sb.push_back({rom[exp_pc[7:2]], exp_pc + 32'd4});
    step();
    exp_cnt = exp_cnt + 32'd1;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_instr"}, ifid_instr, e[63:32]);
      chk({tag, "_pc4"}, ifid_pc4, e[31:0]);
    end
    chk({tag, "_valid"}, 32'(ifid_valid), 32'd1);
    chk({tag, "_cnt"}, fetch_count, exp_cnt);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_pc = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = 32'h2000_0000 | 32'(i);
    rom[0]  = 32'h2008_0000;
    rom[1]  = 32'h200d_0050;
    rom[2]  = 32'h8dad_0000;
    rom[17] = 32'h0800_0011;
    exp_cnt = 32'd0;
    exp_pc = 32'd0;

    #12;
    chk_reset("rst");
    rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    step();
    redirect_valid = 1'b0;
    chk("idle_addr", imem_addr, 32'd0);
    chk("idle_valid", 32'(ifid_valid), 32'd0);

    pulse_start();
    chk("run0_addr", imem_addr, 32'd0);
    chk("run0_valid", 32'(ifid_valid), 32'd0);
    start = 1'b0;
    fetch("seq0");
    fetch("seq1");
    fetch("seq2");
    for (int i = 0; i < 4; i++) fetch("seqn");
    chk("pc_1c", imem_addr, 32'h1c);

    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    chk("stall_addr", imem_addr, 32'h1c);
    chk("stall_pc4", ifid_pc4, 32'h1c);
    chk("stall_valid", 32'(ifid_valid), 32'd1);
    chk("stall_cnt", fetch_count, exp_cnt);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(ifid_valid), 32'd0);
    chk("flush_addr", imem_addr, 32'h1c);
    fetch("refetch");
    for (int i = 0; i < 8; i++) fetch("to40");
    chk("pc_40", imem_addr, 32'h40);

    redirect_valid = 1'b1;
    redirect_pc = 32'h28;
    stall = 1'b1;
    step();
    redirect_valid = 1'b0;
    stall = 1'b0;
    chk("redir_addr", imem_addr, 32'h28);
    chk("redir_valid", 32'(ifid_valid), 32'd0);
    exp_pc = 32'h28;
    fetch("redir_cap");

    redirect_valid = 1'b1;
    redirect_pc = 32'h44;
    step();
    redirect_valid = 1'b0;
    exp_pc = 32'h44;
    fetch("jself");
    chk("jself_halt", 32'(halted), 32'd1);
    chk("jself_pc", imem_addr, 32'h44);
    step();
    step();
    chk("halt_valid", 32'(ifid_valid), 32'd0);
    chk("halt_pc", imem_addr, 32'h44);
    chk("halt_cnt", fetch_count, exp_cnt);
    pulse_start();
    chk("restart_halted", 32'(halted), 32'd0);
    fetch("restart");

    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("oor_pre_err", 32'(err), 32'd0);
    step();
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_halted", 32'(halted), 32'd1);
    chk("oor_valid", 32'(ifid_valid), 32'd0);
    chk("oor_cnt", fetch_count, exp_cnt);
    pulse_start();
    chk("oor_sticky", 32'(err), 32'd1);
    chk("oor_restart", 32'(halted), 32'd0);

    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_cnt = 32'd0;
    chk("err_clr", 32'(err), 32'd0);
    pulse_start();
    fetch("mis_pre");
    redirect_valid = 1'b1;
    redirect_pc = 32'h06;
    step();
    redirect_valid = 1'b0;
    step();
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_valid", 32'(ifid_valid), 32'd0);
    chk("mis_cnt", fetch_count, exp_cnt);
    pulse_start();
    chk("mis_sticky", 32'(err), 32'd1);

    fetch("pre_async");
    fetch("pre_async2");
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    step();
    #1;
    rst_n = 1'b1;
    step();
    step();
    chk("post_idle_addr", imem_addr, 32'd0);
    chk("post_idle_valid", 32'(ifid_valid), 32'd0);
    chk("post_idle_cnt", fetch_count, 32'd0);
    exp_cnt = 32'd0;
    pulse_start();
    fetch("post_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
